// File: rtl/seg14_scan_sched_if.sv
// Write/commit port of the 14-segment scan scheduler: shadow-buffer writes
// plus the commit handshake and sticky address-error flag.
interface seg14_scan_sched_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [5:0] wr_char;
    logic       commit_req;
    logic       commit_done;
    logic       wr_err;

    modport master (
        output wr_valid, wr_addr, wr_char, commit_req,
        input  wr_ready, commit_done, wr_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_char, commit_req,
        output wr_ready, commit_done, wr_err
    );
endinterface

// File: rtl/seg14_scan_sched.sv
// 12-digit 14-segment scan scheduler with double-buffered message, programmable
// dwell and blank gap, and frame-aligned atomic commit of the shadow buffer.
module seg14_scan_sched #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    seg14_scan_sched_if.slave bus,
    output logic              frame_start,
    output logic [11:0]       sel,
    output logic [13:0]       segm
);

    localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
    localparam logic [TimerW-1:0] DwellLast = TimerW'(DWELL_CYCLES - 1);
    localparam logic [TimerW-1:0] BlankLast = TimerW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    localparam logic [1:0] StOff   = 2'd0;
    localparam logic [1:0] StDwell = 2'd1;
    localparam logic [1:0] StBlank = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        digit_q, digit_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              wr_err_q, wr_err_d;
    logic              frame_start_q, frame_start_d;
    logic              commit_done_q, commit_done_d;
    logic [11:0]       sel_q, sel_d;
    logic [13:0]       segm_q, segm_d;
    logic [11:0][5:0]  shadow_q, shadow_d;
    logic [11:0][5:0]  active_q, active_d;

    logic       enter_dwell;
    logic       copy;
    logic       wr_acc;
    logic [3:0] next_digit;
    logic [5:0] cur_char;

    function automatic logic [13:0] glyph(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'h01: g = 14'b1110_1111_000000;  // A
            6'h02: g = 14'b1111_0001_010010;
            6'h03: g = 14'b1001_1100_000000;
            6'h04: g = 14'b1111_0000_010010;
            6'h05: g = 14'b1001_1110_000000;  // E
            6'h06: g = 14'b1000_1110_000000;
            6'h07: g = 14'b1011_1101_000000;
            6'h08: g = 14'b0110_1111_000000;
            6'h09: g = 14'b1001_0000_010010;
            6'h0A: g = 14'b0111_1000_000000;
            6'h0B: g = 14'b0000_1110_001100;  // K
            6'h0C: g = 14'b0001_1100_000000;
            6'h0D: g = 14'b0110_1100_101000;
            6'h0E: g = 14'b0110_1100_100100;
            6'h0F: g = 14'b1111_1100_000000;
            6'h10: g = 14'b1100_1111_000000;
            6'h11: g = 14'b1111_1100_000100;
            6'h12: g = 14'b1100_1111_000100;
            6'h13: g = 14'b1011_0111_000000;  // S
            6'h14: g = 14'b1000_0000_010010;
            6'h15: g = 14'b0111_1100_000000;
            6'h16: g = 14'b0000_1100_001001;
            6'h17: g = 14'b0110_1100_000101;
            6'h18: g = 14'b0000_0000_101101;
            6'h19: g = 14'b0000_0000_101010;
            6'h1A: g = 14'b1001_0000_001001;
            6'h1B: g = 14'b1111_1100_001001;  // 0
            6'h1C: g = 14'b0110_0000_001000;
            6'h1D: g = 14'b1101_1011_000000;
            6'h1E: g = 14'b1111_0001_000000;
            6'h1F: g = 14'b0110_0111_000000;
            6'h20: g = 14'b1011_0111_000000;
            6'h21: g = 14'b1011_1111_000000;
            6'h22: g = 14'b1110_0000_000000;
            6'h23: g = 14'b1111_1111_000000;
            6'h24: g = 14'b1111_0111_000000;  // 9
            default: g = 14'b0;
        endcase
        return g;
    endfunction

    always_comb begin
        next_digit  = (digit_q == 4'd11) ? 4'd0 : digit_q + 4'd1;
        state_d     = state_q;
        digit_d     = digit_q;
        timer_d     = timer_q + TimerW'(1);
        enter_dwell = 1'b0;
        if (!en) begin
            state_d = StOff;
            digit_d = 4'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                StDwell: begin
                    if (timer_q == DwellLast) begin
                        timer_d = '0;
                        if (BLANK_CYCLES == 0) begin
                            digit_d     = next_digit;
                            enter_dwell = 1'b1;
                        end else begin
                            state_d = StBlank;
                        end
                    end
                end
                StBlank: begin
                    if (timer_q == BlankLast) begin
                        state_d     = StDwell;
                        digit_d     = next_digit;
                        timer_d     = '0;
                        enter_dwell = 1'b1;
                    end
                end
                default: begin
                    state_d     = StDwell;
                    digit_d     = 4'd0;
                    timer_d     = '0;
                    enter_dwell = 1'b1;
                end
            endcase
        end

        frame_start_d = enter_dwell && (digit_d == 4'd0);
        // Commit only on a frame boundary, or at once when the display is dark.
        copy          = pending_q && (!en || (state_q == StOff) || frame_start_d);
        commit_done_d = copy;
        pending_d     = !copy && (pending_q || bus.commit_req);
        wr_acc        = bus.wr_valid && !pending_q;
        wr_err_d      = wr_err_q || (wr_acc && (bus.wr_addr > 4'd11));

        shadow_d = shadow_q;
        for (int i = 0; i < 12; i++) begin
            if (wr_acc && (bus.wr_addr == 4'(i))) shadow_d[i] = bus.wr_char;
        end
        active_d = copy ? shadow_q : active_q;

        // Look up from the post-copy buffer so the first digit of a new frame is fresh.
        cur_char = 6'h00;
        for (int i = 0; i < 12; i++) begin
            if (digit_d == 4'(i)) cur_char = active_d[i];
        end
        sel_d  = '0;
        segm_d = '0;
        if (state_d == StDwell) begin
            sel_d  = 12'b1 << digit_d;
            segm_d = glyph(cur_char);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StOff;
            digit_q       <= 4'd0;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            wr_err_q      <= 1'b0;
            frame_start_q <= 1'b0;
            commit_done_q <= 1'b0;
            sel_q         <= '0;
            segm_q        <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            wr_err_q      <= wr_err_d;
            frame_start_q <= frame_start_d;
            commit_done_q <= commit_done_d;
            sel_q         <= sel_d;
            segm_q        <= segm_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign bus.wr_ready    = ~pending_q;
    assign bus.commit_done = commit_done_q;
    assign bus.wr_err      = wr_err_q;
    assign frame_start     = frame_start_q;
    assign sel             = sel_q;
    assign segm            = segm_q;

endmodule

// File: tb/tb_seg14_scan_sched.sv
// Randomized scoreboard bench: two scanners (with and without blank gap) share
// stimulus; an arithmetic frame-position model predicts every cycle's outputs.
module tb_seg14_scan_sched;

    typedef struct packed {
        logic [11:0] sel;
        logic [13:0] segm;
        logic        fs;
        logic        cd;
        logic        rdy;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, wr_valid, commit_req;
    logic [3:0] wr_addr;
    logic [5:0] wr_char;

    logic        fs0, fs1;
    logic [11:0] sel0, sel1;
    logic [13:0] segm0, segm1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t exp0[$];
    exp_t exp1[$];

    bit         m_on[2];
    int         m_pos[2];
    bit         m_pend[2];
    bit         m_err[2];
    logic [5:0] m_sh[2][12];
    logic [5:0] m_act[2][12];

    seg14_scan_sched_if bus0 ();
    seg14_scan_sched_if bus1 ();

    assign bus0.wr_valid   = wr_valid;
    assign bus0.wr_addr    = wr_addr;
    assign bus0.wr_char    = wr_char;
    assign bus0.commit_req = commit_req;
    assign bus1.wr_valid   = wr_valid;
    assign bus1.wr_addr    = wr_addr;
    assign bus1.wr_char    = wr_char;
    assign bus1.commit_req = commit_req;

    seg14_scan_sched #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus0),
        .frame_start(fs0), .sel(sel0), .segm(segm0)
    );

    seg14_scan_sched #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus1),
        .frame_start(fs1), .sel(sel1), .segm(segm1)
    );

    always #5 clk = ~clk;

    // Only the characters the bench ever writes need a pattern here.
    function automatic logic [13:0] ref_glyph(input logic [5:0] c);
        case (c)
            6'h01:   return 14'b11101111000000;
            6'h05:   return 14'b10011110000000;
            6'h0B:   return 14'b00001110001100;
            6'h13:   return 14'b10110111000000;
            default: return 14'b0;
        endcase
    endfunction

    task automatic model_step(input int k, input int d, input int b, output exp_t e);
        int f, p, slot, w;
        bit acc, was_on, wrap, copy;
        e = '0;
        f = 12 * (d + b);
        if (!rst_n) begin
            m_on[k] = 0; m_pos[k] = 0; m_pend[k] = 0; m_err[k] = 0;
            for (int i = 0; i < 12; i++) begin
                m_sh[k][i]  = 6'h00;
                m_act[k][i] = 6'h00;
            end
            e.rdy = 1'b1;
        end else begin
            acc    = wr_valid && !m_pend[k];
            was_on = m_on[k];
            if (en) begin
                if (!m_on[k]) begin
                    m_on[k] = 1; m_pos[k] = 0;
                end else begin
                    m_pos[k]++;
                end
            end else begin
                m_on[k] = 0;
            end
            wrap = en && (m_pos[k] % f == 0);
            copy = m_pend[k] && (!en || !was_on || wrap);
            if (copy) for (int i = 0; i < 12; i++) m_act[k][i] = m_sh[k][i];
            if (acc) begin
                if (wr_addr < 4'd12) m_sh[k][wr_addr] = wr_char;
                else m_err[k] = 1;
            end
            m_pend[k] = copy ? 1'b0 : (m_pend[k] || commit_req);
            if (m_on[k]) begin
                p    = m_pos[k] % f;
                slot = p / (d + b);
                w    = p % (d + b);
                if (w < d) begin
                    e.sel  = 12'b1 << slot;
                    e.segm = ref_glyph(m_act[k][slot]);
                end
                e.fs = (p == 0);
            end
            e.cd  = copy;
            e.rdy = !m_pend[k];
            e.err = m_err[k];
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step(0, 4, 2, e);
        exp0.push_back(e);
        model_step(1, 4, 0, e);
        exp1.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic compare(input int k, input exp_t e, input exp_t g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL out%0d cyc=%0d got sel=%03h segm=%04h fs=%0b cd=%0b rdy=%0b err=%0b exp sel=%03h segm=%04h fs=%0b cd=%0b rdy=%0b err=%0b",
                     k, cyc, g.sel, g.segm, g.fs, g.cd, g.rdy, g.err,
                     e.sel, e.segm, e.fs, e.cd, e.rdy, e.err);
        end
    endtask

    always @(negedge clk) begin
        if (exp0.size() != 0)
            compare(0, exp0.pop_front(),
                    {sel0, segm0, fs0, bus0.commit_done, bus0.wr_ready, bus0.wr_err});
        if (exp1.size() != 0)
            compare(1, exp1.pop_front(),
                    {sel1, segm1, fs1, bus1.commit_done, bus1.wr_ready, bus1.wr_err});
    end

    task automatic wr(input logic [3:0] a, input logic [5:0] c);
        wr_valid = 1'b1; wr_addr = a; wr_char = c;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    function automatic bit at_digit(input int dg);
        int p;
        p = m_pos[0] % 72;
        return m_on[0] && (p / 6 == dg) && (p % 6 < 4);
    endfunction

    task automatic wait_digit(input int dg, input string what);
        for (int n = 0; n < 200 && !at_digit(dg); n++) tick();
        checks++;
        if (!at_digit(dg)) begin
            errors++;
            $display("FAIL wait_%s got timeout required digit %0d", what, dg);
        end
    endtask

    function automatic logic [5:0] rnd_char();
        case ($urandom_range(0, 5))
            0:       return 6'h00;
            1:       return 6'h01;
            2:       return 6'h05;
            3:       return 6'h0B;
            4:       return 6'h13;
            default: return 6'($urandom_range(37, 63));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; commit_req = 1'b0;
        wr_addr = 4'd0; wr_char = 6'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Blank message scan across two full frames.
        en = 1'b1;
        repeat (150) tick();

        // Shadow writes and a mid-frame commit.
        wr(4'd0, 6'h05);
        wr(4'd1, 6'h13);
        wr(4'd5, 6'h01);
        commit();
        wr(4'd2, 6'h0B);  // refused while the commit is pending
        for (int n = 0; n < 200 && (m_pend[0] || m_pend[1]); n++) tick();
        checks++;
        if (m_pend[0] || m_pend[1]) begin
            errors++;
            $display("FAIL commit_wait got timeout required pending clear");
        end
        wr(4'd2, 6'h0B);
        repeat (80) tick();

        // Drop enable on digit 7, commit while dark, then restart.
        wait_digit(7, "d7");
        en = 1'b0;
        repeat (2) tick();
        commit();
        tick();
        en = 1'b1;
        repeat (80) tick();

        // Out-of-range address sets the sticky error.
        wr(4'd13, 6'h13);
        repeat (20) tick();

        // Reset during digit 11 with a commit pending.
        wr(4'd3, 6'h01);
        wait_digit(3, "d3");
        commit();
        wait_digit(11, "d11");
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (100) tick();

        for (int n = 0; n < 2500; n++) begin
            wr_valid   = ($urandom_range(0, 3) == 0);
            wr_addr    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                     : 4'($urandom_range(0, 11));
            wr_char    = rnd_char();
            commit_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        wr_valid = 1'b0; commit_req = 1'b0; rst_n = 1'b1;
        tick();

        @(negedge clk);
        #1;
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d queued required 0/0", exp0.size(), exp1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
